// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the wait-stated data-memory responder.
//   state_e      : responder FSM states
//   WORD_W       : data word width
//   WAIT_W       : width of the wait-cycle down-counter
//   is_rejected(): an access is rejected when it is both a load and a store,
//                  or when the byte address is not word aligned
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_rejected(input logic rd, input logic wr,
                                       input logic [1:0] byte_off);
    return (rd & wr) | (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Single-port DEPTH x 32 word array with synchronous write and registered read.
//   clk_i   : clock
//   we_i    : write enable, stores wdata_i at idx_i
//   re_i    : read enable, captures mem[idx_i] into the read register
//   clr_i   : synchronous clear of the read register (has priority over re_i)
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : registered read data
// The array itself is never cleared.
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated responder for the core's data-memory port.
//   Clock, Reset (sync, active high)
//   Mem_Read / Mem_Write : level request inputs
//   Address              : byte address, word index Address[ADDR_W-1:2]
//   Write_Data           : store data
//   Read_Data            : load data, valid while Ready=1
//   Ready                : one-cycle completion pulse
//   Stall                : (Mem_Read|Mem_Write) & ~Ready, combinational
//   Err                  : pulses with Ready for a rejected access
//
// state | meaning
// IDLE  | waiting for a request; loads the wait counter when one is seen
// WAIT  | counting down wait cycles; access performed when counter is 1
// RESP  | Ready pulse (with Err if rejected); always returns to IDLE
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 2048
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [WORD_W-1:0] Write_Data,
  output logic [WORD_W-1:0] Read_Data,
  output logic              Ready,
  output logic              Stall,
  output logic              Err
);

  localparam int IDX_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;

  logic access;
  logic acc_rd;
  logic acc_wr;
  logic reject;
  logic mem_we;
  logic mem_re;
  logic mem_clr;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    access  = 1'b0;
    // The request class comes from the latched copy so an access whose
    // request dropped during WAIT still completes as the same kind.
    acc_rd  = rd_q;
    acc_wr  = wr_q;
    unique case (state_q)
      IDLE: begin
        if (Mem_Read | Mem_Write) begin
          rd_d   = Mem_Read;
          wr_d   = Mem_Write;
          acc_rd = Mem_Read;
          acc_wr = Mem_Write;
          cnt_d  = WAIT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    reject = is_rejected(acc_rd, acc_wr, Address[1:0]);
    if (access) begin
      err_d = reject;
    end
  end

  // Reset gates the array strobes so an in-flight store never commits
  // on the edge that aborts it.
  assign mem_we  = access & ~reject & acc_wr & ~Reset;
  assign mem_re  = access & ~reject & acc_rd & ~Reset;
  assign mem_clr = Reset | (access & reject);

  mem_word_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (Clock),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .clr_i   (mem_clr),
    .idx_i   (Address[ADDR_W-1:2]),
    .wdata_i (Write_Data),
    .rdata_o (Read_Data)
  );

  assign Ready = (state_q == RESP);
  assign Err   = Ready & err_q;
  assign Stall = (Mem_Read | Mem_Write) & ~Ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_CYCLES=2 (index 0)
// and one with WAIT_CYCLES=0 (index 1), each driven independently.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mr   [2];
  logic        mw   [2];
  logic [12:0] ad   [2];
  logic [31:0] wd   [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        stl  [2];
  logic        er   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference memory, keyed by dut*8192 + word index.
  logic [31:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_W(13), .WAIT_CYCLES(2), .DEPTH(2048)) u_w2 (
    .Clock(clk), .Reset(rst), .Mem_Read(mr[0]), .Mem_Write(mw[0]),
    .Address(ad[0]), .Write_Data(wd[0]), .Read_Data(rdat[0]),
    .Ready(rdy[0]), .Stall(stl[0]), .Err(er[0]));

  data_mem_responder #(.ADDR_W(13), .WAIT_CYCLES(0), .DEPTH(2048)) u_w0 (
    .Clock(clk), .Reset(rst), .Mem_Read(mr[1]), .Mem_Write(mw[1]),
    .Address(ad[1]), .Write_Data(wd[1]), .Read_Data(rdat[1]),
    .Ready(rdy[1]), .Stall(stl[1]), .Err(er[1]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Behavioural effect of one completed access.
  function automatic void model_apply(input int d, input logic rd, input logic wr,
                                      input logic [12:0] a, input logic [31:0] w,
                                      output logic e, output logic [31:0] r);
    int key;
    key = d * 8192 + int'(a[12:2]);
    e = (rd && wr) || (a[1:0] != 2'b00);
    r = 32'h0;
    if (!e) begin
      if (wr) mdl[key] = w;
      if (rd) r = mdl.exists(key) ? mdl[key] : 32'h0;
    end
  endfunction

  // Called at a negedge. Presents a request and follows it to Ready,
  // returning the Ready cycle offset (-1 on timeout), the number of Stall
  // cycles seen, Err/Read_Data at Ready and the absolute Ready cycle.
  // Returns at the next negedge with the request still held.
  task automatic run_access(input int d, input logic rd, input logic wr,
                            input logic [12:0] a, input logic [31:0] w,
                            output int rc, output int sn, output logic e,
                            output logic [31:0] r, output int ry);
    rc = -1; sn = 0; e = 1'b0; r = 32'h0; ry = -1;
    mr[d] = rd; mw[d] = wr; ad[d] = a; wd[d] = w;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stl[d]) sn++;
      if (rdy[d]) begin
        rc = c; e = er[d]; r = rdat[d]; ry = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drop(input int d);
    mr[d] = 1'b0; mw[d] = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = '0; wd[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b0 || er[d] !== 1'b0 || stl[d] !== 1'b0 || rdat[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: rdy=%b err=%b stall=%b rdata=%h, expected 0 0 0 0",
                 d, rdy[d], er[d], stl[d], rdat[d]);
      end
    end
    mr[0] = 1'b1;
    #1;
    checks++;
    if (stl[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows_req: stall=%b expected 1", stl[0]);
    end
    mr[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load;
    int rc, sn, ry; logic e, ee; logic [31:0] r, er_exp;
    run_access(0, 1'b0, 1'b1, 13'h010, 32'hDEADBEEF, rc, sn, e, r, ry);
    drop(0);
    model_apply(0, 1'b0, 1'b1, 13'h010, 32'hDEADBEEF, ee, er_exp);
    checks++;
    if (rc !== 3 || sn !== 3 || e !== 1'b0) begin
      errors++;
      $display("FAIL store_timing: ready_cycle=%0d stall_cycles=%0d err=%b expected 3 3 0", rc, sn, e);
    end
    run_access(0, 1'b1, 1'b0, 13'h010, 32'h0, rc, sn, e, r, ry);
    drop(0);
    model_apply(0, 1'b1, 1'b0, 13'h010, 32'h0, ee, er_exp);
    checks++;
    if (rc !== 3 || sn !== 3 || e !== 1'b0 || r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_after_store: ready_cycle=%0d stall=%0d err=%b data=%h expected 3 3 0 deadbeef",
               rc, sn, e, r);
    end
  endtask

  task automatic test_back_to_back;
    int rc, sn, ry, ry0; logic e, ee; logic [31:0] r, rx, v0, v4;
    v0 = $urandom; v4 = $urandom;
    run_access(1, 1'b0, 1'b1, 13'h000, v0, rc, sn, e, r, ry);
    model_apply(1, 1'b0, 1'b1, 13'h000, v0, ee, rx);
    run_access(1, 1'b0, 1'b1, 13'h004, v4, rc, sn, e, r, ry);
    model_apply(1, 1'b0, 1'b1, 13'h004, v4, ee, rx);
    run_access(1, 1'b1, 1'b0, 13'h000, 32'h0, rc, sn, e, r, ry0);
    checks++;
    if (rc !== 1 || sn !== 1 || r !== v0) begin
      errors++;
      $display("FAIL b2b_load0: ready_cycle=%0d stall=%0d data=%h expected 1 1 %h", rc, sn, r, v0);
    end
    run_access(1, 1'b1, 1'b0, 13'h004, 32'h0, rc, sn, e, r, ry);
    drop(1);
    checks++;
    if (rc !== 1 || sn !== 1 || r !== v4) begin
      errors++;
      $display("FAIL b2b_load4: ready_cycle=%0d stall=%0d data=%h expected 1 1 %h", rc, sn, r, v4);
    end
    checks++;
    if (ry - ry0 !== 2) begin
      errors++;
      $display("FAIL b2b_period: ready spacing=%0d expected 2", ry - ry0);
    end
  endtask

  task automatic test_misaligned;
    int rc, sn, ry; logic e; logic [31:0] r;
    run_access(0, 1'b1, 1'b0, 13'h013, 32'h0, rc, sn, e, r, ry);
    drop(0);
    checks++;
    if (rc !== 3 || e !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_err: ready_cycle=%0d err=%b data=%h expected 3 1 0", rc, e, r);
    end
    run_access(0, 1'b1, 1'b0, 13'h010, 32'h0, rc, sn, e, r, ry);
    drop(0);
    checks++;
    if (r !== mdl[16'h0004] || e !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_mem_unchanged: data=%h err=%b expected %h 0", r, e, mdl[16'h0004]);
    end
  endtask

  task automatic test_both_high;
    int rc, sn, ry; logic e, ee; logic [31:0] r, rx, v;
    v = $urandom;
    run_access(0, 1'b0, 1'b1, 13'h020, v, rc, sn, e, r, ry);
    drop(0);
    model_apply(0, 1'b0, 1'b1, 13'h020, v, ee, rx);
    run_access(0, 1'b1, 1'b1, 13'h020, 32'h1234, rc, sn, e, r, ry);
    drop(0);
    checks++;
    if (rc !== 3 || e !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL both_high_err: ready_cycle=%0d err=%b data=%h expected 3 1 0", rc, e, r);
    end
    run_access(0, 1'b1, 1'b0, 13'h020, 32'h0, rc, sn, e, r, ry);
    drop(0);
    checks++;
    if (r !== v) begin
      errors++;
      $display("FAIL both_high_no_write: data=%h expected %h", r, v);
    end
  endtask

  task automatic test_reset_mid;
    int rc, sn, ry, pulses; logic e, ee; logic [31:0] r, rx;
    run_access(0, 1'b0, 1'b1, 13'h040, 32'hA5A5_0001, rc, sn, e, r, ry);
    drop(0);
    model_apply(0, 1'b0, 1'b1, 13'h040, 32'hA5A5_0001, ee, rx);
    mw[0] = 1'b1; ad[0] = 13'h040; wd[0] = 32'h55;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    pulses = rdy[0] ? 1 : 0;
    mw[0] = 1'b0; rst = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (rdy[0]) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_ready: ready pulses=%0d expected 0", pulses);
    end
    @(negedge clk);
    run_access(0, 1'b1, 1'b0, 13'h040, 32'h0, rc, sn, e, r, ry);
    drop(0);
    checks++;
    if (r !== 32'hA5A5_0001 || rc !== 3) begin
      errors++;
      $display("FAIL reset_mid_store_discarded: data=%h ready_cycle=%0d expected a5a50001 3", r, rc);
    end
  endtask

  task automatic test_random;
    int rc, sn, ry, w8; logic e, ee, rd, wr; logic [31:0] r, rx, v; logic [12:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        v = $urandom;
        a = 13'(12'h100 + k * 4);
        run_access(d, 1'b0, 1'b1, a, v, rc, sn, e, r, ry);
        model_apply(d, 1'b0, 1'b1, a, v, ee, rx);
      end
      drop(d);
      for (int n = 0; n < 30; n++) begin
        w8 = int'($urandom_range(0, 7));
        a = 13'(12'h100 + w8 * 4);
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        case ($urandom_range(0, 9))
          0:       begin rd = 1'b1; wr = 1'b1; end
          1, 2, 3: begin rd = 1'b0; wr = 1'b1; end
          default: begin rd = 1'b1; wr = 1'b0; end
        endcase
        v = $urandom;
        run_access(d, rd, wr, a, v, rc, sn, e, r, ry);
        model_apply(d, rd, wr, a, v, ee, rx);
        if ($urandom_range(0, 2) == 0) begin
          drop(d);
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        checks++;
        if (rc !== wait_of(d) + 1 || sn !== wait_of(d) + 1 || e !== ee) begin
          errors++;
          $display("FAIL rand_timing dut%0d #%0d: ready_cycle=%0d stall=%0d err=%b expected %0d %0d %b",
                   d, n, rc, sn, e, wait_of(d) + 1, wait_of(d) + 1, ee);
        end
        if (rd || ee) begin
          checks++;
          if (r !== rx) begin
            errors++;
            $display("FAIL rand_data dut%0d #%0d addr=%h: data=%h expected %h", d, n, a, r, rx);
          end
        end
      end
      drop(d);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_both_high();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Wait-stated responder for the processor's data-memory port. It accepts the single-cycle core's load/store requests (Mem_Read, Mem_Write, ALU-result address, rs2 write data) and services each after a programmable number of wait cycles. It holds the core via Stall until the access completes, then returns a one-cycle Ready with the load data. It replaces the zero-latency data memory so the core can be exercised against realistic memory timing.

## Interface
Parameters:
- ADDR_W, 13: byte-address width. Matches the core's Alu_Result[12:0].
- WAIT_CYCLES, 2: wait cycles inserted per access. Legal range 0..15.
- DEPTH, 2048: number of 32-bit words, 2^(ADDR_W-2).

Ports (clock and reset first):
- Clock  in  1  single system clock. All state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset. Sampled on the rising edge of Clock.
- Mem_Read  in  1  load request, level.
- Mem_Write  in  1  store request, level.
- Address  in  ADDR_W  byte address. Word index is Address[ADDR_W-1:2].
- Write_Data  in  32  store data.
- Read_Data  out  32  load data. Valid only while Ready=1.
- Ready  out  1  one-cycle completion pulse.
- Stall  out  1  combinational: (Mem_Read|Mem_Write) & ~Ready. The core freezes PC and register write while Stall=1.
- Err  out  1  one-cycle pulse coinciding with Ready on a rejected access.

## Operation
- States (package enum): IDLE, WAIT, RESP.
- IDLE: if Mem_Read|Mem_Write is sampled high, latch the request class and load the 4-bit counter with WAIT_CYCLES.
  - Counter nonzero: go to WAIT.
  - Counter zero: perform the access and go to RESP.
- WAIT: decrement the counter each cycle. On the edge where the counter is 1, perform the access and go to RESP.
- RESP: Ready=1 for exactly one cycle, then unconditionally return to IDLE.
  - A request still asserted in the following IDLE cycle is a new access.
- Access performed on the edge entering RESP:
  - Store: mem[word] <= Write_Data.
  - Load: Read_Data <= mem[word].
- Rejected accesses: Mem_Read&Mem_Write both high, or Address[1:0]!=0.
  - The wait sequence runs normally.
  - No memory write occurs; Read_Data <= 0; Err=1 together with Ready.
- Initiator rule: Mem_Read, Mem_Write, Address and Write_Data are held stable from request until the Ready cycle inclusive.
  - Inputs are re-sampled only when the access is performed.
  - If the request drops during WAIT, the access still completes and Ready still pulses. Stall is 0 in that case because no request is present.
- Address wrap: none. Every word index below DEPTH is valid.

## Timing
- Reset values: state=IDLE, counter=0, Ready=0, Err=0, Read_Data=0. Stall then follows the request inputs.
- Memory contents are not cleared by Reset.
- Latency: a request first present in cycle 0 gets Ready in cycle WAIT_CYCLES+1.
  - Stall is high in cycles 0..WAIT_CYCLES.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- Reset asserted mid-access (WAIT or RESP):
  - Next cycle is IDLE with Ready=0.
  - A pending store that has not reached RESP is discarded.
- A request arriving in the same cycle Reset is asserted is ignored; it is seen again in the next IDLE cycle if still held.
- Load-after-store to the same word returns the stored value: the store commits before the next access starts.

## Structure
- Shared package mips_mem_pkg: state enum, WORD_W=32, WAIT_W=4.
- One sub-module, mem_word_array: synchronous single-port DEPTH×32 array with write-enable and registered read. It is instantiated once; the FSM and counter live in data_mem_responder.

## Test plan
- WAIT_CYCLES=2, store 0xDEADBEEF to 0x010, then load 0x010 → Stall high for 3 cycles each; Ready in cycle 3; Read_Data=0xDEADBEEF; Err=0.
- WAIT_CYCLES=0, back-to-back loads from 0x000 and 0x004 → Ready every 2nd cycle; Stall high only in each request cycle.
- Load from 0x013 (misaligned) → Ready and Err together in cycle 3; Read_Data=0; memory unchanged.
- Mem_Read=Mem_Write=1 at 0x020 with data 0x1234 → Err pulse; a subsequent load from 0x020 returns the prior value.
- Reset asserted while in WAIT during a store of 0x55 to 0x040 → IDLE next cycle; Ready never pulses; a later load from 0x040 returns the old contents.
